// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port memory: one fetch port, one load/store port.
// One transaction in flight at a time; round-robin on ties; registered read data and ack pulses.
module mem_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              de_req,
    input  logic              de_we,
    input  logic [ADDR_W-1:0] de_addr,
    input  logic [DATA_W-1:0] de_wdata,
    output logic              de_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner,
    output logic [7:0]        conflict_cnt
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_gnt_q, last_gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              de_ack_q, de_ack_d;
    logic [7:0]        conflict_q, conflict_d;
    logic              gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            last_gnt_q  <= 1'b1;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            rdata_q     <= '0;
            if_ack_q    <= 1'b0;
            de_ack_q    <= 1'b0;
            conflict_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_gnt_q  <= last_gnt_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            rdata_q     <= rdata_d;
            if_ack_q    <= if_ack_d;
            de_ack_q    <= de_ack_d;
            conflict_q  <= conflict_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_gnt_d  = last_gnt_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = 1'b0;
        rdata_d     = rdata_q;
        if_ack_d    = 1'b0;
        de_ack_d    = 1'b0;
        conflict_d  = conflict_q;
        // On a tie the side that did not win last time gets the grant
        gnt         = (if_req && de_req) ? ~last_gnt_q : de_req;

        case (state_q)
            IDLE: begin
                if (if_req && de_req && conflict_q != 8'hFF)
                    conflict_d = conflict_q + 8'd1;
                if (if_req || de_req) begin
                    owner_d     = gnt;
                    last_gnt_d  = gnt;
                    we_d        = gnt & de_we;
                    mem_write_d = gnt & de_we;
                    mem_addr_d  = gnt ? de_addr : if_addr;
                    mem_wdata_d = gnt ? de_wdata : '0;
                    cnt_d       = '0;
                    state_d     = ACC;
                end
            end
            ACC: begin
                if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
                    if (!we_q)
                        rdata_d = mem_rdata;
                    if_ack_d = ~owner_q;
                    de_ack_d = owner_q;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign if_ack       = if_ack_q;
    assign de_ack       = de_ack_q;
    assign rdata        = rdata_q;
    assign mem_addr     = mem_addr_q;
    assign mem_write    = mem_write_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = (state_q != IDLE);
    assign owner        = owner_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each with its own memory model; acks are checked against a per-instance expectation queue.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req1, de_req1, de_we1, if_ack1, de_ack1, mem_write1, busy1, owner1;
    logic [7:0]  if_addr1, de_addr1, mem_addr1, conflict1;
    logic [31:0] de_wdata1, rdata1, mem_wdata1, mem_rdata1;

    logic        if_req3, de_req3, de_we3, if_ack3, de_ack3, mem_write3, busy3, owner3;
    logic [7:0]  if_addr3, de_addr3, mem_addr3, conflict3;
    logic [31:0] de_wdata3, rdata3, mem_wdata3, mem_rdata3;

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(8), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1),
        .de_req(de_req1), .de_we(de_we1), .de_addr(de_addr1), .de_wdata(de_wdata1), .de_ack(de_ack1),
        .rdata(rdata1), .mem_addr(mem_addr1), .mem_write(mem_write1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1), .owner(owner1), .conflict_cnt(conflict1)
    );

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(8), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3),
        .de_req(de_req3), .de_we(de_we3), .de_addr(de_addr3), .de_wdata(de_wdata3), .de_ack(de_ack3),
        .rdata(rdata3), .mem_addr(mem_addr3), .mem_write(mem_write3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3), .owner(owner3), .conflict_cnt(conflict3)
    );

    // Memory models: latency 1 reads combinationally, latency 3 adds two register stages
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] p3a, p3b;

    assign mem_rdata1 = mem1[mem_addr1];
    assign mem_rdata3 = p3b;

    always @(posedge clk) begin
        if (mem_write1) mem1[mem_addr1] = mem_wdata1;
    end

    always @(posedge clk) begin
        p3a <= mem3[mem_addr3];
        p3b <= p3a;
        if (mem_write3) mem3[mem_addr3] = mem_wdata3;
    end

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic        owner;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t sb1[$];
    exp_t sb3[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (if_ack1 || de_ack1) begin
            chk("ack_excl1", 32'(if_ack1 & de_ack1), 32'd0);
            if (sb1.size() == 0) begin
                chk("unexpected_ack1", 32'(de_ack1), 32'(if_ack1));
            end else begin
                e = sb1.pop_front();
                chk("ack_owner1", 32'(de_ack1), 32'(e.owner));
                if (e.chk_rd) chk("ack_rdata1", rdata1, e.rd);
            end
        end
        if (if_ack3 || de_ack3) begin
            chk("ack_excl3", 32'(if_ack3 & de_ack3), 32'd0);
            if (sb3.size() == 0) begin
                chk("unexpected_ack3", 32'(de_ack3), 32'(if_ack3));
            end else begin
                e = sb3.pop_front();
                chk("ack_owner3", 32'(de_ack3), 32'(e.owner));
                if (e.chk_rd) chk("ack_rdata3", rdata3, e.rd);
            end
        end
    end

    task automatic txn1(input logic d, input logic we, input logic [7:0] a, input logic [31:0] wd,
                        input logic chkrd, input logic [31:0] exp);
        logic done;
        done = 1'b0;
        sb1.push_back('{owner: d, chk_rd: chkrd, rd: exp});
        if (d) begin
            de_req1 = 1'b1; de_we1 = we; de_addr1 = a; de_wdata1 = wd;
        end else begin
            if_req1 = 1'b1; if_addr1 = a;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (d ? de_ack1 : if_ack1) done = 1'b1;
        end
        chk("txn_ack_seen", 32'(done), 32'd1);
        if_req1 = 1'b0; de_req1 = 1'b0; de_we1 = 1'b0;
        tick();
    endtask

    // Both requests held for n transactions; grants must alternate starting with fetch
    task automatic tie_run(input int n);
        int exp_cnt;
        if_addr1 = 8'h10; de_addr1 = 8'h20; de_we1 = 1'b0;
        for (int k = 0; k < n; k++)
            sb1.push_back('{owner: (k % 2 == 1), chk_rd: 1'b1,
                            rd: (k % 2 == 1) ? 32'h12345678 : 32'hDEADBEEF});
        if_req1 = 1'b1; de_req1 = 1'b1;
        for (int k = 0; k < n; k++) begin
            repeat (2) tick();
            chk("tie_if_ack", 32'(if_ack1), 32'(k % 2 == 0));
            chk("tie_de_ack", 32'(de_ack1), 32'(k % 2 == 1));
            if (k < 4 || k == 253 || k == n - 1) begin
                exp_cnt = (k + 1 > 255) ? 255 : k + 1;
                chk("tie_conflict", 32'(conflict1), 32'(exp_cnt));
            end
            if (k == n - 1) begin
                if_req1 = 1'b0; de_req1 = 1'b0;
            end
            tick();
        end
        repeat (3) tick();
        exp_cnt = (n > 255) ? 255 : n;
        chk("tie_conflict_hold", 32'(conflict1), 32'(exp_cnt));
    endtask

    initial begin
        if_req1 = 0; de_req1 = 0; de_we1 = 0; if_addr1 = 0; de_addr1 = 0; de_wdata1 = 0;
        if_req3 = 0; de_req3 = 0; de_we3 = 0; if_addr3 = 0; de_addr3 = 0; de_wdata3 = 0;
        mem1[8'h10] = 32'hDEADBEEF;
        mem3[8'h00] = 32'h11111111;
        mem3[8'h40] = 32'hCAFEF00D;

        repeat (3) tick();
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr1), 32'd0);
        chk("rst_mem_wdata", mem_wdata1, 32'd0);
        chk("rst_mem_write", 32'(mem_write1), 32'd0);
        chk("rst_rdata", rdata1, 32'd0);
        chk("rst_owner", 32'(owner1), 32'd0);
        chk("rst_conflict", 32'(conflict1), 32'd0);
        chk("rst_acks", 32'({if_ack1, de_ack1}), 32'd0);
        chk("rst_rdata3", rdata3, 32'd0);
        rst = 1'b0;

        // Single fetch, cycle-exact
        if_req1 = 1'b1; if_addr1 = 8'h10;
        sb1.push_back('{owner: 1'b0, chk_rd: 1'b1, rd: 32'hDEADBEEF});
        tick();
        chk("f_mem_addr", 32'(mem_addr1), 32'h10);
        chk("f_busy_c1", 32'(busy1), 32'd1);
        chk("f_noack_c1", 32'(if_ack1), 32'd0);
        tick();
        chk("f_ack_c2", 32'(if_ack1), 32'd1);
        chk("f_rdata_c2", rdata1, 32'hDEADBEEF);
        chk("f_busy_c2", 32'(busy1), 32'd1);
        if_req1 = 1'b0;
        tick();
        chk("f_idle_c3", 32'(busy1), 32'd0);

        // Store: one write pulse, rdata untouched
        de_req1 = 1'b1; de_we1 = 1'b1; de_addr1 = 8'h20; de_wdata1 = 32'h12345678;
        sb1.push_back('{owner: 1'b1, chk_rd: 1'b0, rd: 32'h0});
        tick();
        chk("st_write_c1", 32'(mem_write1), 32'd1);
        chk("st_wdata", mem_wdata1, 32'h12345678);
        chk("st_owner", 32'(owner1), 32'd1);
        tick();
        chk("st_write_c2", 32'(mem_write1), 32'd0);
        chk("st_ack_c2", 32'(de_ack1), 32'd1);
        chk("st_rdata_kept", rdata1, 32'hDEADBEEF);
        de_req1 = 1'b0; de_we1 = 1'b0;
        tick();

        txn1(1'b1, 1'b0, 8'h20, 32'h0, 1'b1, 32'h12345678);
        txn1(1'b0, 1'b0, 8'h10, 32'h0, 1'b1, 32'hDEADBEEF);

        // Fetch won last; after reset the first tie must still go to fetch
        rst = 1'b1; tick(); rst = 1'b0;
        tie_run(4);

        // Reset during the first ACC cycle of a store
        de_req1 = 1'b1; de_we1 = 1'b1; de_addr1 = 8'h30; de_wdata1 = 32'h55AA55AA;
        tick();
        chk("rs_write_c1", 32'(mem_write1), 32'd1);
        rst = 1'b1;
        tick();
        chk("rs_write_off", 32'(mem_write1), 32'd0);
        chk("rs_busy", 32'(busy1), 32'd0);
        chk("rs_no_ack", 32'(de_ack1), 32'd0);
        chk("rs_conflict", 32'(conflict1), 32'd0);
        rst = 1'b0; de_we1 = 1'b0; de_addr1 = 8'h20; if_req1 = 1'b1; if_addr1 = 8'h10;
        sb1.push_back('{owner: 1'b0, chk_rd: 1'b1, rd: 32'hDEADBEEF});
        repeat (2) tick();
        chk("rs_tie_fetch", 32'(if_ack1), 32'd1);
        chk("rs_tie_conflict", 32'(conflict1), 32'd1);
        if_req1 = 1'b0; de_req1 = 1'b0;
        tick();

        // Saturation
        rst = 1'b1; tick(); rst = 1'b0;
        tie_run(300);

        // MEM_LAT = 3 fetch: address held cycles 1-3, data taken from cycle 3
        if_req3 = 1'b1; if_addr3 = 8'h40;
        sb3.push_back('{owner: 1'b0, chk_rd: 1'b1, rd: 32'hCAFEF00D});
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("l3_mem_addr", 32'(mem_addr3), 32'h40);
            chk("l3_busy", 32'(busy3), 32'd1);
            chk("l3_noack", 32'(if_ack3), 32'd0);
        end
        tick();
        chk("l3_ack_c4", 32'(if_ack3), 32'd1);
        chk("l3_rdata", rdata3, 32'hCAFEF00D);
        if_req3 = 1'b0;
        tick();
        chk("l3_idle", 32'(busy3), 32'd0);

        de_req3 = 1'b1; de_we3 = 1'b1; de_addr3 = 8'h41; de_wdata3 = 32'hA5A5A5A5;
        sb3.push_back('{owner: 1'b1, chk_rd: 1'b0, rd: 32'h0});
        tick();
        chk("l3_st_write_c1", 32'(mem_write3), 32'd1);
        tick();
        chk("l3_st_write_c2", 32'(mem_write3), 32'd0);
        tick();
        chk("l3_st_write_c3", 32'(mem_write3), 32'd0);
        chk("l3_st_addr_c3", 32'(mem_addr3), 32'h41);
        tick();
        chk("l3_st_ack_c4", 32'(de_ack3), 32'd1);
        chk("l3_st_rdata_kept", rdata3, 32'hCAFEF00D);
        de_req3 = 1'b0; de_we3 = 1'b0;
        tick();
        chk("l3_st_mem", mem3[8'h41], 32'hA5A5A5A5);
        chk("l3_owner", 32'(owner3), 32'd1);
        chk("l3_conflict", 32'(conflict3), 32'd0);

        repeat (3) tick();
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        chk("sb3_drained", 32'(sb3.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
